// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a host-loaded program memory and hands one
// word at a time to the control unit using the ONSWT/DONE and OFFSWT handshakes.
module instr_sequencer #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          LD_VALID,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [31:0]   LD_DATA,
    output logic          LD_READY,
    input  logic          START,
    input  logic          ABORT,
    output logic [31:0]   INSTR,
    output logic          ONSWT,
    input  logic          DONE,
    input  logic          OFFSWT,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          HALTED,
    output logic          ERR,
    output logic [15:0]   INSTR_CNT
);

    // state | meaning
    // IDLE  | stopped; program may be loaded; START begins a run at PC 0
    // FETCH | synchronous read of mem[PC] in flight
    // ISSUE | decode fetched word; drive it to the control unit or flag illegal
    // WAIT  | instruction outstanding; wait for DONE (or OFFSWT for a halt word)
    // GAP   | one idle cycle between instructions; advance PC
    // HALT  | stopped after halt word or error; load and restart allowed
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    logic [2:0]  state;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic        wait_armed;
    logic        halt_pending;

    logic [2:0]  rd_op;
    logic        rd_illegal;
    logic        rd_halt;

    assign rd_op      = rd_word[2:0];
    assign rd_illegal = (rd_op >= 3'd5);
    assign rd_halt    = (rd_op == 3'd0) && rd_word[7];

    assign LD_READY = (state == S_IDLE) || (state == S_HALT);
    assign BUSY     = (state == S_FETCH) || (state == S_ISSUE) ||
                      (state == S_WAIT)  || (state == S_GAP);

    // Program memory: not reset, so a program survives RSTN.
    always_ff @(posedge CLK) begin
        if (LD_VALID && LD_READY) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

    // Reads only happen in FETCH and writes only in IDLE/HALT, so a load that
    // coincides with START is already in the array when FETCH reads it.
    always_ff @(posedge CLK) begin
        if (state == S_FETCH) begin
            rd_word <= mem[PC];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            INSTR        <= 32'h0;
            ONSWT        <= 1'b0;
            PC           <= '0;
            INSTR_CNT    <= 16'h0;
            HALTED       <= 1'b0;
            ERR          <= 1'b0;
            wait_armed   <= 1'b0;
            halt_pending <= 1'b0;
        end else if (ABORT) begin
            state        <= S_IDLE;
            INSTR        <= 32'h0;
            ONSWT        <= 1'b0;
            wait_armed   <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (START) begin
                        PC        <= '0;
                        INSTR_CNT <= 16'h0;
                        HALTED    <= 1'b0;
                        ERR       <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (rd_illegal) begin
                        ERR   <= 1'b1;
                        INSTR <= 32'h0;
                        ONSWT <= 1'b0;
                        state <= S_HALT;
                    end else begin
                        INSTR        <= rd_word;
                        ONSWT        <= !rd_halt;
                        halt_pending <= rd_halt;
                        wait_armed   <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (halt_pending) begin
                        if (OFFSWT) begin
                            INSTR        <= 32'h0;
                            HALTED       <= 1'b1;
                            halt_pending <= 1'b0;
                            state        <= S_HALT;
                        end
                    end else if (!wait_armed) begin
                        // DONE is registered in the control unit and may still
                        // reflect the previous instruction on this first cycle.
                        wait_armed <= 1'b1;
                    end else if (DONE) begin
                        ONSWT <= 1'b0;
                        INSTR <= 32'h0;
                        if (INSTR_CNT != 16'hFFFF) begin
                            INSTR_CNT <= INSTR_CNT + 16'h1;
                        end
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (PC == LAST_PC) begin
                        ERR   <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        PC    <= PC + AW'(1);
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: reference model predicts each issued word, its wait
// length and the end-of-run status; a negedge monitor scores what the DUT drives.
module tb_instr_sequencer;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RSTN, LD_VALID, START, ABORT, DONE, OFFSWT;
    logic [AW-1:0] LD_ADDR;
    logic [31:0]   LD_DATA;
    logic          LD_READY, ONSWT, BUSY, HALTED, ERR;
    logic [31:0]   INSTR;
    logic [AW-1:0] PC;
    logic [15:0]   INSTR_CNT;

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .START(START), .ABORT(ABORT),
        .INSTR(INSTR), .ONSWT(ONSWT), .DONE(DONE), .OFFSWT(OFFSWT), .PC(PC),
        .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        onswt;
        int          dur;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tb_mem [DEPTH];
    logic [31:0] prog[$];
    int          errors = 0;
    int          checks = 0;
    int          done_delay = 0;
    int          off_delay = 0;
    logic        done_stuck = 1'b0;
    int          exp_pc, exp_cnt;
    logic        exp_err, exp_halted;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Reference: walk the program by the sequencing rules and predict the trace.
    task automatic expect_run();
        int pc = 0;
        int cnt = 0;
        logic [31:0] w;
        exp_t e;
        exp_err = 1'b0;
        exp_halted = 1'b0;
        forever begin
            w = tb_mem[pc];
            if (w[2:0] >= 3'd5) begin
                exp_err = 1'b1;
                break;
            end
            if (w[2:0] == 3'd0 && w[7]) begin
                e.instr = w; e.onswt = 1'b0; e.dur = 0;
                exp_q.push_back(e);
                exp_halted = 1'b1;
                break;
            end
            e.instr = w; e.onswt = 1'b1;
            e.dur = (done_delay + 1 > 2) ? done_delay + 1 : 2;
            exp_q.push_back(e);
            cnt = (cnt < 65535) ? cnt + 1 : cnt;
            if (pc == DEPTH - 1) begin
                exp_err = 1'b1;
                break;
            end
            pc++;
        end
        exp_pc = pc;
        exp_cnt = cnt;
    endtask

    // Control-unit stand-in: DONE rises done_delay cycles into WAIT, OFFSWT
    // off_delay cycles after a halt word appears.
    initial begin
        int busy_cnt = 0;
        int hcnt = 0;
        DONE = 1'b0;
        OFFSWT = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (ONSWT === 1'b1) begin
                busy_cnt++;
                DONE = (busy_cnt > done_delay);
            end else begin
                busy_cnt = 0;
                DONE = done_stuck;
            end
            if (ONSWT !== 1'b1 && INSTR[2:0] === 3'd0 && INSTR[7] === 1'b1) begin
                hcnt++;
                OFFSWT = (hcnt > off_delay);
            end else begin
                hcnt = 0;
                OFFSWT = 1'b0;
            end
        end
    end

    // Monitor: a new non-zero INSTR is an issue event.
    initial begin
        logic [31:0] prev_instr = 32'h0;
        int run_len = 0, zero_len = 0, cur_dur = 0;
        logic cur_onswt = 1'b0, gap_seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RSTN !== 1'b1) begin
                prev_instr = 32'h0; run_len = 0; zero_len = 0; gap_seen = 1'b0; cur_dur = 0;
            end else begin
                if (INSTR !== 32'h0 && INSTR !== prev_instr) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue: got %h expected no issue", INSTR);
                        cur_dur = 0; cur_onswt = ONSWT;
                    end else begin
                        e = exp_q.pop_front();
                        chk("issue_word", INSTR, e.instr);
                        chk("issue_onswt", 32'(ONSWT), 32'(e.onswt));
                        cur_dur = e.dur; cur_onswt = e.onswt;
                    end
                    if (gap_seen) chk("gap_len", 32'(zero_len), 32'd3);
                    run_len = 1; zero_len = 0;
                end else if (INSTR !== 32'h0) begin
                    run_len++;
                    chk("hold_onswt", 32'(ONSWT), 32'(cur_onswt));
                end else begin
                    if (prev_instr !== 32'h0 && BUSY === 1'b1 && cur_dur != 0) begin
                        chk("wait_len", 32'(run_len), 32'(cur_dur));
                        gap_seen = 1'b1;
                    end
                    zero_len++;
                end
                if (BUSY !== 1'b1) gap_seen = 1'b0;
                prev_instr = INSTR;
            end
        end
    end

    task automatic load_prog();
        foreach (prog[i]) begin
            @(negedge CLK);
            LD_VALID = 1'b1; LD_ADDR = AW'(i); LD_DATA = prog[i];
            tb_mem[i] = prog[i];
        end
        @(negedge CLK);
        LD_VALID = 1'b0;
    endtask

    task automatic final_checks();
        chk("end_pc", 32'(PC), 32'(exp_pc));
        chk("end_cnt", 32'(INSTR_CNT), 32'(exp_cnt));
        chk("end_err", 32'(ERR), 32'(exp_err));
        chk("end_halted", 32'(HALTED), 32'(exp_halted));
        chk("end_instr", INSTR, 32'h0);
        chk("end_onswt", 32'(ONSWT), 32'h0);
        chk("end_ld_ready", 32'(LD_READY), 32'h1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    // Runs with random writes attempted throughout; none may land while busy.
    task automatic run_program(input bit co, input logic [31:0] co_data);
        if (co) tb_mem[0] = co_data;
        expect_run();
        @(negedge CLK);
        START = 1'b1;
        if (co) begin
            LD_VALID = 1'b1; LD_ADDR = '0; LD_DATA = co_data;
        end
        @(negedge CLK);
        START = 1'b0;
        LD_VALID = 1'b0;
        for (int i = 0; i < 600 && BUSY === 1'b1; i++) begin
            LD_VALID = 1'b1; LD_ADDR = AW'($urandom); LD_DATA = $urandom;
            @(negedge CLK);
        end
        LD_VALID = 1'b0;
        chk("run_timeout_busy", 32'(BUSY), 32'h0);
        if (BUSY === 1'b1) begin
            ABORT = 1'b1; @(negedge CLK); ABORT = 1'b0;
            exp_q.delete();
        end
        final_checks();
    endtask

    task automatic abort_mid_wait(input bit use_reset);
        prog = '{32'h09, 32'h0A, 32'h03, 32'h04, 32'h80};
        load_prog();
        done_delay = 10; done_stuck = 1'b0; off_delay = 1;
        expect_run();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (int i = 0; i < 200 && !(INSTR_CNT === 16'd1 && ONSWT === 1'b1); i++) @(negedge CLK);
        chk("mid_wait_reached", 32'(ONSWT), 32'h1);
        chk("mid_ld_ready", 32'(LD_READY), 32'h0);
        if (use_reset) RSTN = 1'b0; else ABORT = 1'b1;
        @(posedge CLK);
        #1;
        RSTN = 1'b1; ABORT = 1'b0;
        chk("stop_instr", INSTR, 32'h0);
        chk("stop_onswt", 32'(ONSWT), 32'h0);
        chk("stop_busy", 32'(BUSY), 32'h0);
        chk("stop_ld_ready", 32'(LD_READY), 32'h1);
        chk("stop_pc", 32'(PC), use_reset ? 32'h0 : 32'h1);
        chk("stop_cnt", 32'(INSTR_CNT), use_reset ? 32'h0 : 32'h1);
        exp_q.delete();
        done_delay = 1;
        run_program(1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        w = $urandom;
        w[7] = 1'b0;
        w[2:0] = 3'($urandom_range(0, 4));
        if (w[2:0] == 3'd0) w[3] = 1'b1;
        return w;
    endfunction

    initial begin
        int len, kind;
        logic [31:0] w;
        RSTN = 1'b0; LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = 32'h0; START = 1'b0; ABORT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_onswt", 32'(ONSWT), 32'h0);
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_cnt", 32'(INSTR_CNT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_halted", 32'(HALTED), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        chk("rst_ld_ready", 32'(LD_READY), 32'h1);
        RSTN = 1'b1;

        prog = '{32'h09, 32'h0A, 32'h03, 32'h04, 32'h80};
        load_prog();
        done_delay = 2; off_delay = 0;
        run_program(1'b0, 32'h0);

        done_delay = 15; off_delay = 2;
        run_program(1'b0, 32'h0);

        done_delay = 0; done_stuck = 1'b1;
        run_program(1'b0, 32'h0);
        done_stuck = 1'b0;

        prog = '{32'h09, 32'h0A, 32'h05, 32'h03};
        load_prog();
        done_delay = 1;
        run_program(1'b0, 32'h0);

        prog = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h0C, 32'h11, 32'h22, 32'h33};
        load_prog();
        run_program(1'b0, 32'h0);

        abort_mid_wait(1'b0);
        abort_mid_wait(1'b1);

        @(negedge CLK); ABORT = 1'b1; START = 1'b1;
        @(negedge CLK); ABORT = 1'b0; START = 1'b0;
        chk("abort_beats_start", 32'(BUSY), 32'h0);

        prog = '{32'h01, 32'h02, 32'h80};
        load_prog();
        done_delay = 0;
        run_program(1'b1, 32'h04);

        for (int r = 0; r < 20; r++) begin
            kind = $urandom_range(0, 9);
            len = $urandom_range(1, DEPTH - 1);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_legal());
            if (kind == 0) begin
                w = $urandom; w[2:0] = 3'($urandom_range(5, 7));
                prog[$urandom_range(0, len - 1)] = w;
            end else if (kind == 1) begin
                while (prog.size() < DEPTH) prog.push_back(rand_legal());
            end else begin
                w = 32'h0; w[7] = 1'b1; w[6:3] = 4'($urandom);
                prog.push_back(w);
            end
            load_prog();
            done_delay = $urandom_range(0, 4);
            done_stuck = 1'($urandom);
            off_delay = $urandom_range(0, 3);
            run_program(1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
